// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and the fetch queue entry layout for the instruction fetch controller.
// Imported by fetch_ctrl and fetch_queue.
package fetch_ctrl_pkg;

    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            cancel;
        logic            exc;
        logic            arrived;
    } fq_entry_t;

    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_queue.sv
// In-order queue of outstanding fetches (fetch_queue): circular storage with wrap-bit pointers,
// bulk cancel, and in-order matching of returned instructions to the oldest waiting entry.
module fetch_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push_i,
    input  fq_entry_t push_entry_i,
    input  logic      pop_i,
    input  logic      cancel_all_i,
    input  logic      data_ok_i,
    output fq_entry_t head_o,
    output logic      head_hit_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int         IW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [IW:0] DEPTH_W = (IW+1)'(QDEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(QDEPTH - 1);

    fq_entry_t         mem_q [QDEPTH];
    logic [IW-1:0]     rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic              rd_wrap_q, rd_wrap_d, wr_wrap_q, wr_wrap_d;
    logic [QDEPTH-1:0] slot_valid;
    logic [IW:0]       scan_slot;
    logic              tgt_found;
    logic [IW-1:0]     tgt_idx;
    logic              data_hit;

    assign empty_o = (rd_idx_q == wr_idx_q) && (rd_wrap_q == wr_wrap_q);
    assign full_o  = (rd_idx_q == wr_idx_q) && (rd_wrap_q != wr_wrap_q);
    assign head_o  = mem_q[rd_idx_q];

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_wrap_d = rd_wrap_q;
        if (pop_i && !empty_o) begin
            if (rd_idx_q == LAST_IDX) begin
                rd_idx_d  = '0;
                rd_wrap_d = ~rd_wrap_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_wrap_d = wr_wrap_q;
        if (push_i && !full_o) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d  = '0;
                wr_wrap_d = ~wr_wrap_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // A slot holds a live entry when it lies between the pointers, taking the wrap into account.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (rd_wrap_q == wr_wrap_q) begin
                slot_valid[i] = (IW'(i) >= rd_idx_q) && (IW'(i) < wr_idx_q);
            end else begin
                slot_valid[i] = (IW'(i) >= rd_idx_q) || (IW'(i) < wr_idx_q);
            end
        end
    end

    // Returned data belongs to the oldest entry still waiting on the bus, searched from the head.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = rd_idx_q;
        scan_slot = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            scan_slot = {1'b0, rd_idx_q} + (IW+1)'(k);
            if (scan_slot >= DEPTH_W) begin
                scan_slot = scan_slot - DEPTH_W;
            end
            if (!tgt_found && slot_valid[scan_slot[IW-1:0]]
                && !mem_q[scan_slot[IW-1:0]].arrived && !mem_q[scan_slot[IW-1:0]].exc) begin
                tgt_found = 1'b1;
                tgt_idx   = scan_slot[IW-1:0];
            end
        end
    end

    assign data_hit   = data_ok_i && tgt_found;
    assign head_hit_o = data_hit && (tgt_idx == rd_idx_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_idx_q  <= '0;
            rd_wrap_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_idx_q  <= rd_idx_d;
            rd_wrap_q <= rd_wrap_d;
            wr_idx_q  <= wr_idx_d;
            wr_wrap_q <= wr_wrap_d;
            if (cancel_all_i) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    mem_q[i].cancel <= 1'b1;
                end
            end
            if (data_hit) begin
                mem_q[tgt_idx].arrived <= 1'b1;
            end
            if (push_i && !full_o) begin
                mem_q[wr_idx_q] <= push_entry_i;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues bus requests, and presents the oldest
// fetched instruction (or address-error marker) to decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o
);

    logic [31:0] pc_q, pc_d;
    logic        misaligned;
    logic        can_issue;
    logic        push_exc;
    logic        push;
    logic        pop;
    logic        head_ready;
    logic        q_full, q_empty, head_hit;
    fq_entry_t   head, push_entry;

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .cancel_all_i (redirect_i),
        .data_ok_i    (inst_data_ok),
        .head_o       (head),
        .head_hit_o   (head_hit),
        .empty_o      (q_empty),
        .full_o       (q_full)
    );

    // A misaligned PC never reaches the bus; it is queued as an already-complete error entry.
    always_comb begin
        misaligned = pc_misaligned(pc_q);
        can_issue  = resetn && !q_full && !redirect_i;
        inst_req   = can_issue && !misaligned;
        inst_addr  = pc_q;
        push_exc   = can_issue && misaligned;
        push       = push_exc || (inst_req && inst_addr_ok);
        push_entry = '{pc: pc_q, cancel: 1'b0, exc: push_exc, arrived: push_exc};
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Cancelled heads drain as soon as their data is in, without waiting for decode.
    always_comb begin
        head_ready = head.arrived || head_hit;
        pop        = 1'b0;
        if (!q_empty) begin
            if (head.cancel) begin
                pop = head_ready;
            end else begin
                pop = ready_i && (head_ready || head.exc);
            end
        end
    end

    always_comb begin
        valid_o     = !q_empty && !head.cancel;
        cancelled_o = !q_empty && head.cancel;
        exc_o       = !q_empty && head.exc;
        pc_o        = q_empty ? 32'd0 : head.pc;
        exccode_o   = exc_o ? EXC_ADEL : 5'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table for the multi-cycle corner cases, a reset
// sequence, then randomized traffic compared against a queue-based reference model.
module tb_fetch_ctrl;

    localparam int          QD     = 2;
    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam logic [4:0]  ADEL   = 5'd4;
    localparam int          NVEC   = 26;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic [4:0]  exccode_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        aok, dok, rdy, rdr;
        logic [31:0] rpc;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic        eCanc, eExc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          cancel, exc, arrived;
    } ment_t;

    vec_t        tbl [NVEC];
    ment_t       mq [$];
    logic [31:0] mpc;

    fetch_ctrl #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .cancelled_o   (cancelled_o),
        .exc_o         (exc_o),
        .exccode_o     (exccode_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic aok, logic dok, logic rdy, logic rdr, logic [31:0] rpc,
                                   logic eReq, logic [31:0] eAddr, logic eValid,
                                   logic [31:0] ePc, logic eCanc, logic eExc);
        vec_t v;
        v.aok = aok; v.dok = dok; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.ePc = ePc;
        v.eCanc = eCanc; v.eExc = eExc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic eValid, input logic [31:0] ePc,
                            input logic eCanc, input logic eExc);
        checkOutput({tag, " inst_req"},    32'(inst_req),    32'(eReq));
        checkOutput({tag, " inst_addr"},   inst_addr,        eAddr);
        checkOutput({tag, " valid_o"},     32'(valid_o),     32'(eValid));
        checkOutput({tag, " pc_o"},        pc_o,             ePc);
        checkOutput({tag, " cancelled_o"}, 32'(cancelled_o), 32'(eCanc));
        checkOutput({tag, " exc_o"},       32'(exc_o),       32'(eExc));
        checkOutput({tag, " exccode_o"},   32'(exccode_o),   32'(eExc ? ADEL : 5'd0));
    endtask

    task automatic driveIdle();
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        ready_i       = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        resetn = 1'b0;
        driveIdle();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset inst_req",    32'(inst_req),    32'd0);
        checkOutput("reset valid_o",     32'(valid_o),     32'd0);
        checkOutput("reset pc_o",        pc_o,             32'd0);
        checkOutput("reset cancelled_o", 32'(cancelled_o), 32'd0);
        checkOutput("reset exc_o",       32'(exc_o),       32'd0);
        checkOutput("reset exccode_o",   32'(exccode_o),   32'd0);
        resetn = 1'b1;
        mq.delete();
        mpc = RST_PC;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        inst_addr_ok  = v.aok;
        inst_data_ok  = v.dok;
        ready_i       = v.rdy;
        redirect_i    = v.rdr;
        redirect_pc_i = v.rpc;
        #1;
        checkAll($sformatf("vec%0d", idx), v.eReq, v.eAddr, v.eValid, v.ePc, v.eCanc, v.eExc);
    endtask

    // Reference model: one cycle of the fetch rules applied to a plain queue of entries.
    task automatic modelStep(input bit aok, input bit dok, input bit rdy, input bit rdr,
                             input logic [31:0] rpc);
        int    t;
        bit    full, mis, pop, hdata;
        ment_t e;
        t    = -1;
        full = (mq.size() == QD);
        mis  = (mpc[1:0] != 2'b00);
        pop  = 0;
        if (dok) begin
            foreach (mq[i]) begin
                if (t < 0 && !mq[i].arrived && !mq[i].exc) t = i;
            end
        end
        if (mq.size() > 0) begin
            hdata = mq[0].arrived || (t == 0);
            if (mq[0].cancel) pop = hdata;
            else              pop = rdy && (hdata || mq[0].exc);
        end
        if (t >= 0) begin
            e = mq[t]; e.arrived = 1; mq[t] = e;
        end
        if (rdr) begin
            foreach (mq[i]) begin
                e = mq[i]; e.cancel = 1; mq[i] = e;
            end
        end
        if (pop) void'(mq.pop_front());
        if (rdr) begin
            mpc = rpc;
        end else if (!full) begin
            if (mis) begin
                e.pc = mpc; e.cancel = 0; e.exc = 1; e.arrived = 1;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end else if (aok) begin
                e.pc = mpc; e.cancel = 0; e.exc = 0; e.arrived = 0;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic randomCycle(input int n);
        bit          aok, dok, rdy, rdr, empty;
        logic [31:0] rpc;
        aok = ($urandom_range(3) != 0);
        dok = ($urandom_range(1) != 0);
        rdy = ($urandom_range(3) != 0);
        rdr = ($urandom_range(15) == 0);
        rpc = $urandom;
        if ($urandom_range(7) != 0) rpc[1:0] = 2'b00;
        @(negedge clk);
        inst_addr_ok  = aok;
        inst_data_ok  = dok;
        ready_i       = rdy;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        #1;
        empty = (mq.size() == 0);
        checkAll($sformatf("rnd%0d", n),
                 (mq.size() != QD) && (mpc[1:0] == 2'b00) && !rdr,
                 mpc,
                 !empty && !mq[0].cancel,
                 empty ? 32'd0 : mq[0].pc,
                 !empty && mq[0].cancel,
                 !empty && mq[0].exc);
        modelStep(aok, dok, rdy, rdr, rpc);
    endtask

    initial begin
        resetn = 1'b0;
        driveIdle();

        tbl[0]  = mkVec(1,0,1,0,32'h0,        1,32'hbfc00000,0,32'h0,        0,0);
        tbl[1]  = mkVec(1,1,1,0,32'h0,        1,32'hbfc00004,1,32'hbfc00000,0,0);
        tbl[2]  = mkVec(1,1,1,0,32'h0,        1,32'hbfc00008,1,32'hbfc00004,0,0);
        tbl[3]  = mkVec(1,0,1,0,32'h0,        1,32'hbfc0000c,1,32'hbfc00008,0,0);
        tbl[4]  = mkVec(1,0,1,0,32'h0,        0,32'hbfc00010,1,32'hbfc00008,0,0);
        tbl[5]  = mkVec(1,0,1,0,32'h0,        0,32'hbfc00010,1,32'hbfc00008,0,0);
        tbl[6]  = mkVec(1,0,0,1,32'h80001000, 0,32'hbfc00010,1,32'hbfc00008,0,0);
        tbl[7]  = mkVec(1,0,1,0,32'h0,        0,32'h80001000,0,32'hbfc00008,1,0);
        tbl[8]  = mkVec(1,1,0,0,32'h0,        0,32'h80001000,0,32'hbfc00008,1,0);
        tbl[9]  = mkVec(1,1,0,0,32'h0,        1,32'h80001000,0,32'hbfc0000c,1,0);
        tbl[10] = mkVec(0,0,0,0,32'h0,        1,32'h80001004,1,32'h80001000,0,0);
        tbl[11] = mkVec(1,0,0,1,32'h80000002, 0,32'h80001004,1,32'h80001000,0,0);
        tbl[12] = mkVec(1,0,0,0,32'h0,        0,32'h80000002,0,32'h80001000,1,0);
        tbl[13] = mkVec(0,1,0,0,32'h0,        0,32'h80000006,0,32'h80001000,1,0);
        tbl[14] = mkVec(0,0,0,0,32'h0,        0,32'h80000006,1,32'h80000002,0,1);
        tbl[15] = mkVec(0,0,1,0,32'h0,        0,32'h8000000a,1,32'h80000002,0,1);
        tbl[16] = mkVec(0,0,0,1,32'hbfc00100, 0,32'h8000000a,1,32'h80000006,0,1);
        tbl[17] = mkVec(0,0,0,0,32'h0,        1,32'hbfc00100,0,32'h80000006,1,1);
        tbl[18] = mkVec(0,0,0,0,32'h0,        1,32'hbfc00100,0,32'h0,        0,0);
        tbl[19] = mkVec(1,0,0,0,32'h0,        1,32'hbfc00100,0,32'h0,        0,0);
        tbl[20] = mkVec(1,1,0,0,32'h0,        1,32'hbfc00104,1,32'hbfc00100,0,0);
        tbl[21] = mkVec(1,1,0,0,32'h0,        0,32'hbfc00108,1,32'hbfc00100,0,0);
        tbl[22] = mkVec(1,0,0,0,32'h0,        0,32'hbfc00108,1,32'hbfc00100,0,0);
        tbl[23] = mkVec(1,0,1,0,32'h0,        0,32'hbfc00108,1,32'hbfc00100,0,0);
        tbl[24] = mkVec(1,0,1,0,32'h0,        1,32'hbfc00108,1,32'hbfc00104,0,0);
        tbl[25] = mkVec(0,0,0,0,32'h0,        1,32'hbfc0010c,1,32'hbfc00108,0,0);

        $display("[TB] directed vector table");
        doReset();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i], i);
        end

        $display("[TB] reset with two requests outstanding");
        doReset();
        @(negedge clk);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inst_addr_ok = 1'b0;
        #1;
        checkAll("midrst full", 1'b0, 32'hbfc00008, 1'b1, 32'hbfc00000, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        checkAll("midrst asserted", 1'b0, RST_PC, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkAll("midrst released", 1'b1, RST_PC, 1'b0, 32'd0, 1'b0, 1'b0);

        $display("[TB] randomized traffic against reference model");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            randomCycle(n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
